// File: rtl/gate_pkg.sv
// Shared types and the bitwise gate evaluator for the shared gate arbiter.
package gate_pkg;

    localparam int unsigned GATE_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    // Evaluated at maximum width; callers truncate to their operand width.
    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b,
        input op_e                   op
    );
        logic [GATE_MAX_W-1:0] res;
        res = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shared_gate_arbiter_if.sv
// Requester and response handshake bundle for the shared gate arbiter.
interface shared_gate_arbiter_if
    import gate_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    op_e  [NUM_REQ-1:0]            req_op;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WIDTH-1:0]              rsp_data;

    // Requesters plus response consumer.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after i_ptr.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant_c,
    output logic [$clog2(NUM_REQ)-1:0] o_idx_c,
    output logic                       o_any_c
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] w_idx;

    // Modulo wrap keeps non-power-of-two counts from touching unused indices.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_any_c && i_req[w_idx]) begin
                o_any_c = 1'b1;
                o_idx_c = w_idx;
            end
        end
        if (o_any_c) begin
            o_grant_c[o_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_gate_arbiter.sv
// Round-robin sequencer sharing one registered bitwise gate unit among requesters.
module shared_gate_arbiter
    import gate_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_gate_arbiter_if.slave bus,
    output logic                 busy,
    output logic [15:0]          txn_count
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 16;

    state_e             r_state;
    state_e             w_state_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_rsp_valid;
    logic               r_busy;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [CNT_W-1:0]   r_txn_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any_grant;
    logic               w_load;
    logic               w_done;
    logic [WIDTH-1:0]   w_result;
    logic [ID_W-1:0]    w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_grant_idx),
        .o_any_c   (w_any_grant)
    );

    assign w_result   = WIDTH'(gate_eval(GATE_MAX_W'(bus.req_a[w_grant_idx]),
                                         GATE_MAX_W'(bus.req_b[w_grant_idx]),
                                         bus.req_op[w_grant_idx]));
    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; ready is gated by rst so nothing is accepted while held in reset.
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_done        = 1'b0;
        bus.req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_grant && !rst) begin
                    bus.req_ready = w_grant;
                    w_load        = 1'b1;
                    w_state_next  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result, pointer and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_txn_count <= '0;
        end else if (w_load) begin
            r_rr_ptr    <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_rsp_id    <= w_grant_idx;
            r_rsp_data  <= w_result;
        end else if (w_done) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_txn_count <= r_txn_count + CNT_W'(1);
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign busy          = r_busy;
    assign txn_count     = r_txn_count;

endmodule
